// File: rtl/coffee_dispenser_pkg.sv
// Shared encodings for the drink-preparation sequencer: state codes, product
// codes, counter width and the strobe priority encoder.
package coffee_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CUP   = 3'd1;
  localparam logic [2:0] S_GRIND = 3'd2;
  localparam logic [2:0] S_PUMP  = 3'd3;
  localparam logic [2:0] S_MILK  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  typedef logic [1:0] prod_t;

  localparam prod_t PROD_NONE = 2'b00;
  localparam prod_t PROD_CAP  = 2'b01;
  localparam prod_t PROD_ES   = 2'b10;
  localparam prod_t PROD_ESL  = 2'b11;

  // Long espresso wins over espresso, which wins over cappuccino.
  function automatic prod_t pick_prod(input logic cap, input logic es, input logic esl);
    if (esl)      return PROD_ESL;
    else if (es)  return PROD_ES;
    else if (cap) return PROD_CAP;
    return PROD_NONE;
  endfunction

endpackage

// File: rtl/coffee_dispenser_if.sv
// Signal bundle between the vending front end and the drink sequencer.
interface coffee_dispenser_if;
  logic       cap;
  logic       es;
  logic       esl;
  logic       cup_present;
  logic       cup_drop;
  logic       grind;
  logic       pump;
  logic       milk;
  logic       busy;
  logic       done;
  logic       err;
  logic       lost;
  logic [2:0] state_reg;

  modport master (
    output cap, es, esl, cup_present,
    input  cup_drop, grind, pump, milk, busy, done, err, lost, state_reg
  );

  modport slave (
    input  cap, es, esl, cup_present,
    output cup_drop, grind, pump, milk, busy, done, err, lost, state_reg
  );
endinterface

// File: rtl/coffee_dispenser_dn_counter.sv
// Loadable down counter that parks at zero; times every sequencer state.
module dn_counter
  import coffee_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/coffee_dispenser.sv
// Drink-preparation sequencer: cup drop, grind, pump and (cappuccino) milk,
// each timed by a shared down counter reloaded on every state change.
module coffee_dispenser
  import coffee_pkg::*;
#(
  parameter int CUP_TIMEOUT  = 8,
  parameter int GRIND_CYC    = 4,
  parameter int ES_PUMP_CYC  = 6,
  parameter int ESL_PUMP_CYC = 10,
  parameter int MILK_CYC     = 5
) (
  input  logic            clock,
  input  logic            reset,
  coffee_dispenser_if.slave bus
);

  localparam logic [CNT_W-1:0] CUP_LD   = CNT_W'(CUP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GRIND_LD = CNT_W'(GRIND_CYC - 1);
  localparam logic [CNT_W-1:0] ES_LD    = CNT_W'(ES_PUMP_CYC - 1);
  localparam logic [CNT_W-1:0] ESL_LD   = CNT_W'(ESL_PUMP_CYC - 1);
  localparam logic [CNT_W-1:0] MILK_LD  = CNT_W'(MILK_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  prod_t            prod;
  prod_t            prod_nxt;
  logic             strobe;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             lost_q;

  assign strobe = bus.cap | bus.es | bus.esl;

  always_comb begin
    state_nxt = state;
    prod_nxt  = prod;
    case (state)
      S_IDLE: if (strobe) begin
        state_nxt = S_CUP;
        prod_nxt  = pick_prod(bus.cap, bus.es, bus.esl);
      end
      S_CUP: begin
        if (bus.cup_present) state_nxt = S_GRIND;
        else if (cnt_zero)   state_nxt = S_ERR;
      end
      S_GRIND: begin
        if (!bus.cup_present) state_nxt = S_ERR;
        else if (cnt_zero)    state_nxt = S_PUMP;
      end
      S_PUMP: begin
        if (!bus.cup_present) state_nxt = S_ERR;
        else if (cnt_zero)    state_nxt = (prod == PROD_CAP) ? S_MILK : S_DONE;
      end
      S_MILK: begin
        if (!bus.cup_present) state_nxt = S_ERR;
        else if (cnt_zero)    state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        prod_nxt  = PROD_NONE;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter is reloaded with N-1 whenever the state changes, so the exit
  // edge lands exactly N cycles after entry.
  always_comb begin
    cnt_load = (state_nxt != state);
    cnt_val  = '0;
    case (state_nxt)
      S_CUP:   cnt_val = CUP_LD;
      S_GRIND: cnt_val = GRIND_LD;
      S_PUMP:  cnt_val = (prod == PROD_ESL) ? ESL_LD : ES_LD;
      S_MILK:  cnt_val = MILK_LD;
      default: cnt_val = '0;
    endcase
  end

  dn_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      prod   <= PROD_NONE;
      lost_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      prod   <= prod_nxt;
      lost_q <= strobe && (state inside {S_CUP, S_GRIND, S_PUMP, S_MILK, S_DONE});
    end
  end

  assign bus.state_reg = state;
  assign bus.cup_drop  = (state == S_CUP);
  assign bus.grind     = (state == S_GRIND);
  assign bus.pump      = (state == S_PUMP);
  assign bus.milk      = (state == S_MILK);
  assign bus.done      = (state == S_DONE);
  assign bus.err       = (state == S_ERR);
  assign bus.busy      = (state != S_IDLE) && (state != S_ERR);
  assign bus.lost      = lost_q;

endmodule

// File: doc/coffee_dispenser.md
# coffee_dispenser

Drink-preparation sequencer on the output side of the coffee vending FSM. It consumes the single-cycle product strobes `cap`, `es` and `esl` and runs a timed actuator sequence: cup drop, grind, pump, and milk for cappuccino only. It reports `busy`, `done` and `err` back to the front panel.

## Interface
Parameters:
- `CUP_TIMEOUT`, 8: max cycles in CUP waiting for `cup_present`.
- `GRIND_CYC`, 4: grinder-on cycles.
- `ES_PUMP_CYC`, 6: pump cycles for espresso and cappuccino.
- `ESL_PUMP_CYC`, 10: pump cycles for long espresso.
- `MILK_CYC`, 5: milk-valve cycles, cappuccino only.
- All parameters are in the range 1..65535.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low.
- `cap`  in  1: one-cycle strobe, cappuccino ordered.
- `es`  in  1: one-cycle strobe, espresso ordered.
- `esl`  in  1: one-cycle strobe, long espresso ordered.
- `cup_present`  in  1: level, cup sensor.
- `cup_drop`  out  1: cup release actuator.
- `grind`  out  1: grinder motor.
- `pump`  out  1: water pump.
- `milk`  out  1: milk valve.
- `busy`  out  1: high in every state except IDLE and ERR.
- `done`  out  1: one-cycle pulse, drink finished.
- `err`  out  1: fault latched.
- `lost`  out  1: one-cycle pulse, strobe arrived while not IDLE.
- `state_reg`  out  3: current state, for debug and LEDs.

## Operation
- States: IDLE=0, CUP=1, GRIND=2, PUMP=3, MILK=4, DONE=5, ERR=6. Code 7 is illegal and next-state is IDLE.
- All outputs except `lost` are Moore, decoded combinationally from `state_reg`:
  - `cup_drop` is high in CUP.
  - `grind` is high in GRIND.
  - `pump` is high in PUMP.
  - `milk` is high in MILK.
  - `done` is high in DONE.
  - `err` is high in ERR.
- `lost` is registered.
- Product register `prod[1:0]`: 01 = cap, 10 = es, 11 = esl (same code as the panel `sel`). It loads only in IDLE.
- Simultaneous strobes: priority is esl > es > cap. The losers are dropped with no `lost` pulse.
- IDLE → CUP on any strobe. `prod` and the counter load on the same edge.
- CUP:
  - → GRIND on the first edge with `cup_present`=1, including the first CUP cycle.
  - → ERR after `CUP_TIMEOUT` CUP cycles without `cup_present`.
- GRIND → PUMP after exactly `GRIND_CYC` cycles.
- PUMP: lasts `ESL_PUMP_CYC` cycles if prod=11, otherwise `ES_PUMP_CYC`. Then → MILK if prod=01, else → DONE.
- MILK → DONE after `MILK_CYC` cycles.
- DONE → IDLE after 1 cycle. `prod` clears to 00.
- Cup removed: `cup_present`=0 sampled in GRIND, PUMP or MILK → ERR immediately. All actuators are off from the next cycle.
- ERR is absorbing until `reset`. Strobes in ERR are ignored, with no `lost` pulse.
- `lost`: a strobe sampled in CUP, GRIND, PUMP, MILK or DONE raises `lost` for the following cycle. The sequence is unaffected.
- Counter: 16-bit down counter. It loads N−1 on state entry and the state exits on the edge where the count is 0, so a state lasts exactly N cycles.

## Timing
- Reset values: `state_reg`=0, `prod`=0, counter=0. All outputs are 0.
- Reset is asynchronous: assertion mid-sequence drops all actuators immediately.
- Latency: a strobe sampled at edge t puts CUP in cycle t+1.
- Minimum sequence lengths, with cup present at entry:
  - espresso: 1 + `GRIND_CYC` + `ES_PUMP_CYC` + 1 cycles of `busy`.
  - long espresso: `ESL_PUMP_CYC` replaces `ES_PUMP_CYC`.
  - cappuccino: adds `MILK_CYC`.
- A new strobe is accepted the cycle after DONE, i.e. in IDLE.

## Structure
- Package `coffee_pkg`: state encodings, product codes `PROD_NONE`/`PROD_CAP`/`PROD_ES`/`PROD_ESL` (2-bit), counter width constant 16.
- Sub-module `dn_counter`:
  - ports: `clock`, `reset`, `load`, `load_val[15:0]`.
  - output: `zero`.
  - one instance, loaded by the FSM on every state change.

## Test plan
Default parameters; strobe sampled at edge 0 unless noted.
- Espresso, `cup_present`=1 → CUP in cycle 1, `grind` in cycles 2–5, `pump` in 6–11, `done` in 12, IDLE in 13; `busy` high for 12 cycles.
- Long espresso → `pump` in cycles 6–15, `done` in 16; `milk` never asserted.
- Cappuccino → `pump` in 6–11, `milk` in 12–16, `done` in 17.
- `cup_present`=0 for the whole run → `cup_drop` in cycles 1–8, `err` from cycle 9; a later `es` strobe causes no state change and no `lost`; only `reset` returns to IDLE.
- `es` strobe in cycle 4 during an espresso → `lost` in cycle 5, timing unchanged. Separately, `es`+`esl` together in IDLE → long-espresso sequence.
- Cup removed in cycle 7 of a cappuccino → ERR from cycle 8, `pump`=0. Separately, `reset` low in cycle 3 → all outputs 0 asynchronously, `state_reg`=0.
